// File: rtl/wave_gen_pkg.sv
// -----------------------------------------------------------------------------
// wave_gen_pkg
// Shared types and default widths for the waveform-generator phase sequencer.
//   wave_sel_e  : waveform select driven to the output mux
//   seq_state_e : sequencer FSM states
//   cfg_t       : one complete configuration word (tuning word, waveform,
//                 sweep enable, sweep step, sweep limit), sized at the
//                 default widths below
// -----------------------------------------------------------------------------
package wave_gen_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int PHASE_W_DEF = 12;
  localparam int STEP_W_DEF  = 16;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SIN = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [ACC_W_DEF-1:0]  tw;
    wave_sel_e             wave_sel;
    logic                  sweep_en;
    logic [STEP_W_DEF-1:0] step;
    logic [ACC_W_DEF-1:0]  limit;
  } cfg_t;

endpackage

// File: rtl/phase_accumulator.sv
// -----------------------------------------------------------------------------
// phase_accumulator
// ACC_W-bit phase accumulator with carry-out detection and registered outputs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_clear         : force the accumulator to zero (generator idle)
//   i_advance       : add i_tw this cycle (accepted sample strobe)
//   i_tw            : active tuning word
//   o_carry_next    : carry the addition would produce this cycle (combinational,
//                     used by the sequencer to decide wrap-time actions)
//   o_phase         : top PHASE_W bits of the accumulator
//   o_phase_vld     : high the cycle after an accepted advance
//   o_wrap          : high with o_phase_vld when that advance carried out
// -----------------------------------------------------------------------------
module phase_accumulator #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_advance,
  input  logic [ACC_W-1:0]   i_tw,
  output logic               o_carry_next,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_phase_vld,
  output logic               o_wrap
);

  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] r_acc_p1;
  logic             r_vld_p1;
  logic             r_wrap_p1;

  assign w_sum        = {1'b0, r_acc_p1} + {1'b0, i_tw};
  assign o_carry_next = w_sum[ACC_W];

  // Stage p0 -> p1: accumulate and register valid/wrap alongside the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_wrap_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= i_advance;
      r_wrap_p1 <= i_advance & w_sum[ACC_W];
      if (i_clear) begin
        r_acc_p1 <= '0;
      end else if (i_advance) begin
        r_acc_p1 <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign o_phase     = r_acc_p1[ACC_W-1 -: PHASE_W];
  assign o_phase_vld = r_vld_p1;
  assign o_wrap      = r_wrap_p1;

endmodule

// File: rtl/wave_phase_sequencer.sv
// -----------------------------------------------------------------------------
// wave_phase_sequencer
// Phase-accumulator controller for the waveform shapers. Config arrives over a
// valid/ready port; while running, a new config is parked in a shadow register
// and only takes effect at a phase wrap so the waveform never glitches. An
// optional linear sweep adds a step to the tuning word at every wrap, falling
// back to the base tuning word once it exceeds the limit or overflows.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : run request (0 = idle, accumulator held at zero)
//   sample_en         : sample strobe; accumulator advances only when high
//   cfg_valid/ready   : config handshake
//   cfg_tuning_word   : base phase increment per sample
//   cfg_wave_sel      : 0 saw, 1 tri, 2 square, 3 sine
//   cfg_sweep_en      : per-wrap sweep enable
//   cfg_sweep_step    : tuning-word increment per wrap (zero-extended)
//   cfg_sweep_limit   : upper tuning-word bound for the sweep
//   phase             : top PHASE_W bits of the accumulator
//   phase_valid       : high the cycle after each accepted sample strobe
//   wave_sel          : active waveform select
//   wrap_pulse        : accumulator carried out (coincident with phase_valid)
//   update_pending    : shadow config waiting for a wrap
// -----------------------------------------------------------------------------
module wave_phase_sequencer
  import wave_gen_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int STEP_W  = STEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sample_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_tuning_word,
  input  logic [1:0]         cfg_wave_sel,
  input  logic               cfg_sweep_en,
  input  logic [STEP_W-1:0]  cfg_sweep_step,
  input  logic [ACC_W-1:0]   cfg_sweep_limit,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic [1:0]         wave_sel,
  output logic               wrap_pulse,
  output logic               update_pending
);

  seq_state_e       r_state;
  logic             r_cfg_ready;
  logic             r_update_pending;
  cfg_t             r_shadow;

  logic [ACC_W-1:0]  r_tw;
  logic [ACC_W-1:0]  r_base_tw;
  logic [ACC_W-1:0]  r_limit;
  logic [STEP_W-1:0] r_step;
  logic              r_sweep_en;
  wave_sel_e         r_wave_sel;

  cfg_t w_port_cfg;
  cfg_t w_load_src;
  logic w_hs;
  logic w_clear;
  logic w_advance;
  logic w_carry;
  logic w_wrap_now;
  logic w_apply_pend;
  logic w_load_port;
  logic w_load;

  // Next tuning word for a sweep step: reload base on overflow or when the
  // stepped value passes the limit.
  function automatic logic [ACC_W-1:0] sweep_next(
    input logic [ACC_W-1:0]  tw,
    input logic [ACC_W-1:0]  base,
    input logic [ACC_W-1:0]  limit,
    input logic [STEP_W-1:0] step
  );
    logic [ACC_W:0] sum;
    sum = {1'b0, tw} + {{(ACC_W+1-STEP_W){1'b0}}, step};
    if (sum[ACC_W] || (sum[ACC_W-1:0] > limit)) begin
      sweep_next = base;
    end else begin
      sweep_next = sum[ACC_W-1:0];
    end
  endfunction

  always_comb begin
    w_port_cfg          = '0;
    w_port_cfg.tw       = cfg_tuning_word;
    w_port_cfg.wave_sel = wave_sel_e'(cfg_wave_sel);
    w_port_cfg.sweep_en = cfg_sweep_en;
    w_port_cfg.step     = cfg_sweep_step;
    w_port_cfg.limit    = cfg_sweep_limit;
  end

  assign w_hs       = cfg_valid & r_cfg_ready;
  // Dropping enable clears the accumulator in the same edge that leaves RUN,
  // so a late sample strobe cannot sneak one more step through.
  assign w_clear    = (r_state == S_IDLE) | ~enable;
  assign w_advance  = sample_en & ~w_clear;
  assign w_wrap_now = w_advance & w_carry;

  // A zero tuning word can never carry, so any accepted sample counts as the
  // apply point; leaving for IDLE applies immediately.
  assign w_apply_pend = (r_state == S_PENDING) &
                        (~enable | (w_advance & (w_carry | (r_tw == '0))));

  // Direct loads happen in IDLE, and also when RUN drops to IDLE in the same
  // cycle as a handshake (there is no later wrap to wait for).
  assign w_load_port = w_hs & ((r_state == S_IDLE) |
                               ((r_state == S_RUN) & ~enable));
  assign w_load      = w_load_port | w_apply_pend;
  assign w_load_src  = (r_state == S_PENDING) ? r_shadow : w_port_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cfg_ready      <= 1'b1;
      r_update_pending <= 1'b0;
      r_shadow         <= '0;
      r_tw             <= '0;
      r_base_tw        <= '0;
      r_limit          <= '0;
      r_step           <= '0;
      r_sweep_en       <= 1'b0;
      r_wave_sel       <= WAVE_SAW;
    end else begin
      // Active configuration: a load (direct or from shadow) beats a sweep step
      if (w_load) begin
        r_tw       <= w_load_src.tw;
        r_base_tw  <= w_load_src.tw;
        r_limit    <= w_load_src.limit;
        r_step     <= w_load_src.step;
        r_sweep_en <= w_load_src.sweep_en;
        r_wave_sel <= w_load_src.wave_sel;
      end else if ((r_state == S_RUN) && w_wrap_now && r_sweep_en) begin
        r_tw <= sweep_next(r_tw, r_base_tw, r_limit, r_step);
      end

      case (r_state)
        S_IDLE: begin
          r_cfg_ready      <= 1'b1;
          r_update_pending <= 1'b0;
          if (enable) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_hs) begin
            // Captured after this edge's wrap decision, so a handshake that
            // coincides with a wrap waits for the following one.
            r_shadow         <= w_port_cfg;
            r_state          <= S_PENDING;
            r_cfg_ready      <= 1'b0;
            r_update_pending <= 1'b1;
          end
        end
        S_PENDING: begin
          if (w_apply_pend) begin
            r_state          <= enable ? S_RUN : S_IDLE;
            r_cfg_ready      <= 1'b1;
            r_update_pending <= 1'b0;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_cfg_ready      <= 1'b1;
          r_update_pending <= 1'b0;
        end
      endcase
    end
  end

  phase_accumulator #(
    .ACC_W   (ACC_W),
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_advance    (w_advance),
    .i_tw         (r_tw),
    .o_carry_next (w_carry),
    .o_phase      (phase),
    .o_phase_vld  (phase_valid),
    .o_wrap       (wrap_pulse)
  );

  assign cfg_ready      = r_cfg_ready;
  assign update_pending = r_update_pending;
  assign wave_sel       = r_wave_sel;

endmodule
